cfg_frame_loader: RTL and testbench
===================================

# cfg_frame_loader

Serial configuration loader for the pcbfpga logic fabric, sitting directly upstream of the per-tile LUT and DFF primitives. Deserialises a framed bitstream, validates each frame, and drives the registered INIT vector and DFF option flags of each tile. Asserts a done flag when the end-of-configuration frame is accepted, then ignores further input until reset.

## Interface
- NUM_TILES, 16, number of LUT/DFF tiles configured (1..255)
- K, 4, LUT input count; INIT field is 2**K bits (K in 3..6, so the field is a whole number of bytes)

- CLK  in  1  fabric configuration clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- CFG_DI  in  1  serial config data, MSB first
- CFG_VALID  in  1  CFG_DI sampled only on edges where high
- LUT_INIT  out  NUM_TILES*2**K  tile t INIT at bits [t*2**K +: 2**K]
- FF_EN_USED  out  NUM_TILES  per-tile DFF ENABLE_USED
- FF_RST_USED  out  NUM_TILES  per-tile DFF RST_USED
- CFG_BUSY  out  1  high while a frame is being received (after sync, through commit)
- CFG_DONE  out  1  sticky; end-of-configuration frame accepted
- CFG_ERR  out  1  sticky; at least one frame rejected

## Operation
- Frame fields, in order: SYNC 8'hA5, ADDR 8 bits, INIT 2**K bits, FLAGS 8 bits (bit0 EN_USED, bit1 RST_USED, bits 7:2 ignored), optional CRC 8 bits (see Configuration).
- States: HUNT, ADDR, INIT, FLAGS, CRC, COMMIT, DONE.
- HUNT: 8-bit shift register of accepted bits; transition to ADDR on the bit that completes 8'hA5. Comparison is done on every accepted bit, so the pattern may start at any bit position.
- ADDR/INIT/FLAGS/CRC: a bit counter advances per accepted bit. Fields are collected into a frame buffer, not into the outputs.
- COMMIT, one cycle, independent of CFG_VALID:
  - ADDR < NUM_TILES and check passes: write tile ADDR.
  - ADDR == 8'hFF and check passes: go to DONE, set CFG_DONE; payload is discarded.
  - Any other ADDR, or check failure: discard the frame, set CFG_ERR.
  - In every case except DONE, return to HUNT.
- DONE: terminal state. All input is ignored and outputs hold until RST_N.
- A bit arriving with CFG_VALID high during COMMIT is dropped.
- Rewriting the same tile: the last accepted frame wins. Untouched tiles keep their reset values.
- CFG_VALID low: all state holds, with no timeout.

## Timing
- Reset values: LUT_INIT all 0, FF_EN_USED 0, FF_RST_USED 0, CFG_BUSY 0, CFG_DONE 0, CFG_ERR 0. FSM enters HUNT and all shift registers and counters clear.
- RST_N low mid-frame: the frame is aborted immediately and asynchronously. Previously committed tiles are also cleared.
- Latency: the last frame bit is sampled at edge N, the FSM is in COMMIT during cycle N..N+1, and outputs, CFG_DONE and CFG_ERR update at edge N+1.
- CFG_BUSY rises at the edge that accepts the last SYNC bit and falls at the COMMIT exit edge.
- Minimum frame spacing: 1 idle cycle, the COMMIT cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- CFG_FRAME_LOADER_CRC_EN defined:
  - The CRC field is present.
  - CRC-8, polynomial 0x07, init 8'h00, no reflection, computed over ADDR, INIT and FLAGS, MSB first.
  - The check passes only if the received CRC equals the computed CRC.
- Undefined:
  - No CRC field and no CRC state; FLAGS goes straight to COMMIT.
  - The check always passes.

## Test plan
- Reset, then one frame A5/03/16'hCAFE/8'h03 (with correct CRC when enabled) -> at edge N+1, LUT_INIT[63:48]=16'hCAFE, FF_EN_USED[3]=1, FF_RST_USED[3]=1; all other bits 0; CFG_ERR=0.
- Same frame with CFG_VALID toggled low for 1 to 5 cycles between random bits -> identical result; CFG_BUSY stays high through the gaps.
- Junk bits 1011_0100_1 followed by an A5 frame for tile 0, INIT 16'h8000 -> sync found mid-stream, LUT_INIT[15:0]=16'h8000.
- Frame with ADDR=8'h20 (NUM_TILES=16) -> no output change, CFG_ERR=1. A following valid frame for tile 1 is still committed. With the macro defined: a flipped CRC bit -> CFG_ERR=1 and no write.
- Frame ADDR=8'hFF -> CFG_DONE=1 at N+1, CFG_BUSY=0. A subsequent valid tile-2 frame leaves LUT_INIT unchanged.
- Drive RST_N low for 1 cycle after 20 bits of a frame for tile 5, after tile 0 was already committed -> all outputs 0. A fresh full frame is then accepted normally.

Source files
------------

// File: rtl/cfg_frame_loader_if.sv
// Serial configuration stream interface for cfg_frame_loader.
//   cfg_di    : serial configuration data, MSB first
//   cfg_valid : cfg_di is sampled only on rising edges where this is high
// master drives the stream (bitstream source), slave receives it (the loader).
interface cfg_frame_loader_if;
  logic cfg_di;
  logic cfg_valid;

  modport master (output cfg_di, output cfg_valid);
  modport slave  (input  cfg_di, input  cfg_valid);
endinterface

// File: rtl/cfg_frame_loader.sv
// Serial configuration loader for the LUT/DFF fabric.
// Deserialises framed bitstream (SYNC A5, ADDR, INIT, FLAGS [, CRC]), validates each
// frame and commits it to the registered per-tile INIT vector and DFF option flags.
// Optional feature macro: CFG_FRAME_LOADER_CRC_EN adds a CRC-8 (poly 0x07) field and check.
// Ports:
//   clk, rst_n     : configuration clock, asynchronous active-low reset
//   cfg            : serial stream (cfg_di, cfg_valid), slave side
//   lut_init_o     : tile t INIT at [t*2**K +: 2**K]
//   ff_en_used_o   : per-tile DFF ENABLE_USED
//   ff_rst_used_o  : per-tile DFF RST_USED
//   cfg_busy_o     : frame in progress (last SYNC bit through commit)
//   cfg_done_o     : sticky, end-of-configuration frame accepted
//   cfg_err_o      : sticky, at least one frame rejected
module cfg_frame_loader #(
  parameter int unsigned NUM_TILES = 16,
  parameter int unsigned K         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cfg_frame_loader_if.slave             cfg,
  output logic [NUM_TILES*(1<<K)-1:0]   lut_init_o,
  output logic [NUM_TILES-1:0]          ff_en_used_o,
  output logic [NUM_TILES-1:0]          ff_rst_used_o,
  output logic                          cfg_busy_o,
  output logic                          cfg_done_o,
  output logic                          cfg_err_o
);

  localparam int unsigned InitW = 1 << K;
  localparam int unsigned LutW  = NUM_TILES * InitW;

  typedef enum logic [2:0] {
    StHunt,
    StAddr,
    StInit,
    StFlags,
`ifdef CFG_FRAME_LOADER_CRC_EN
    StCrc,
`endif
    StCommit,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           sync_q, sync_d;
  logic [6:0]           cnt_q, cnt_d;
  logic [7:0]           addr_q, addr_d;
  logic [InitW-1:0]     init_q, init_d;
  // Only the last two FLAGS bits received (bit1, bit0) are meaningful.
  logic [1:0]           flags_q, flags_d;
  logic [LutW-1:0]      lut_q, lut_d;
  logic [NUM_TILES-1:0] en_q, en_d;
  logic [NUM_TILES-1:0] rst_q, rst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 check_ok;
  logic                 accept;

`ifdef CFG_FRAME_LOADER_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic [7:0] rx_crc_q, rx_crc_d;
  logic [7:0] crc_step;
  logic       crc_fb;

  // Bit-serial CRC-8, MSB first, poly x^8+x^2+x+1.
  assign crc_fb   = crc_q[7] ^ cfg.cfg_di;
  assign crc_step = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
  assign check_ok = (rx_crc_q == crc_q);
`else
  assign check_ok = 1'b1;
`endif

  assign accept = cfg.cfg_valid;

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    init_d  = init_q;
    flags_d = flags_q;
    lut_d   = lut_q;
    en_d    = en_q;
    rst_d   = rst_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef CFG_FRAME_LOADER_CRC_EN
    crc_d    = crc_q;
    rx_crc_d = rx_crc_q;
`endif
    unique case (state_q)
      StHunt: begin
        if (accept) begin
          sync_d = {sync_q[6:0], cfg.cfg_di};
          if (sync_d == 8'hA5) begin
            // Clear so stale sync bits cannot pair with the next hunt's bits.
            sync_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = StAddr;
`ifdef CFG_FRAME_LOADER_CRC_EN
            crc_d   = '0;
`endif
          end
        end
      end
      StAddr: begin
        if (accept) begin
          addr_d = {addr_q[6:0], cfg.cfg_di};
`ifdef CFG_FRAME_LOADER_CRC_EN
          crc_d  = crc_step;
`endif
          cnt_d  = cnt_q + 7'd1;
          if (cnt_q == 7'd7) begin
            cnt_d   = '0;
            state_d = StInit;
          end
        end
      end
      StInit: begin
        if (accept) begin
          init_d = {init_q[InitW-2:0], cfg.cfg_di};
`ifdef CFG_FRAME_LOADER_CRC_EN
          crc_d  = crc_step;
`endif
          cnt_d  = cnt_q + 7'd1;
          if (cnt_q == 7'(InitW - 1)) begin
            cnt_d   = '0;
            state_d = StFlags;
          end
        end
      end
      StFlags: begin
        if (accept) begin
          flags_d = {flags_q[0], cfg.cfg_di};
          cnt_d   = cnt_q + 7'd1;
`ifdef CFG_FRAME_LOADER_CRC_EN
          crc_d   = crc_step;
          if (cnt_q == 7'd7) begin
            cnt_d   = '0;
            state_d = StCrc;
          end
`else
          if (cnt_q == 7'd7) begin
            cnt_d   = '0;
            state_d = StCommit;
          end
`endif
        end
      end
`ifdef CFG_FRAME_LOADER_CRC_EN
      StCrc: begin
        if (accept) begin
          rx_crc_d = {rx_crc_q[6:0], cfg.cfg_di};
          cnt_d    = cnt_q + 7'd1;
          if (cnt_q == 7'd7) begin
            cnt_d   = '0;
            state_d = StCommit;
          end
        end
      end
`endif
      StCommit: begin
        // Input is ignored here; any bit presented this cycle is dropped.
        busy_d  = 1'b0;
        state_d = StHunt;
        if (check_ok && (32'(addr_q) < NUM_TILES)) begin
          for (int unsigned t = 0; t < NUM_TILES; t++) begin
            if (addr_q == 8'(t)) begin
              lut_d[t*InitW +: InitW] = init_q;
              en_d[t]                 = flags_q[0];
              rst_d[t]                = flags_q[1];
            end
          end
        end else if (check_ok && (addr_q == 8'hFF)) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          err_d = 1'b1;
        end
      end
      StDone: ;
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StHunt;
      sync_q   <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      init_q   <= '0;
      flags_q  <= '0;
      lut_q    <= '0;
      en_q     <= '0;
      rst_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef CFG_FRAME_LOADER_CRC_EN
      crc_q    <= '0;
      rx_crc_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      init_q   <= init_d;
      flags_q  <= flags_d;
      lut_q    <= lut_d;
      en_q     <= en_d;
      rst_q    <= rst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef CFG_FRAME_LOADER_CRC_EN
      crc_q    <= crc_d;
      rx_crc_q <= rx_crc_d;
`endif
    end
  end

  assign lut_init_o    = lut_q;
  assign ff_en_used_o  = en_q;
  assign ff_rst_used_o = rst_q;
  assign cfg_busy_o    = busy_q;
  assign cfg_done_o    = done_q;
  assign cfg_err_o     = err_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Self-checking bench for cfg_frame_loader (NUM_TILES=16, K=4).
module tb_cfg_frame_loader;
  localparam int NT = 16;
  localparam int IW = 16;
`ifdef CFG_FRAME_LOADER_CRC_EN
  localparam int FrameBits = 8 + 8 + IW + 8 + 8;
`else
  localparam int FrameBits = 8 + 8 + IW + 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cfg_frame_loader_if u_if();

  logic [NT*IW-1:0] lut_init;
  logic [NT-1:0]    ff_en, ff_rst;
  logic             busy, done, err;

  cfg_frame_loader #(.NUM_TILES(NT), .K(4)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (u_if),
    .lut_init_o    (lut_init),
    .ff_en_used_o  (ff_en),
    .ff_rst_used_o (ff_rst),
    .cfg_busy_o    (busy),
    .cfg_done_o    (done),
    .cfg_err_o     (err)
  );

  int compared = 0;
  int mismatched = 0;

  bit tx_q[$];

  // Reference model: per-tile contents and sticky flags.
  logic [IW-1:0] exp_lut[NT];
  bit            exp_en[NT];
  bit            exp_rst[NT];
  bit            exp_done, exp_err;

  function automatic void model_clear();
    for (int t = 0; t < NT; t++) begin
      exp_lut[t] = '0; exp_en[t] = 1'b0; exp_rst[t] = 1'b0;
    end
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endfunction

  function automatic logic [NT*IW+2*NT-1:0] exp_vec();
    logic [NT*IW-1:0] l;
    logic [NT-1:0]    e, r;
    for (int t = 0; t < NT; t++) begin
      l[t*IW +: IW] = exp_lut[t]; e[t] = exp_en[t]; r[t] = exp_rst[t];
    end
    return {l, e, r};
  endfunction

  // CRC-8 poly 0x07 over ADDR, INIT, FLAGS, processed a byte at a time.
  function automatic logic [7:0] crc8(logic [7:0] a, logic [IW-1:0] ini, logic [7:0] f);
    logic [IW+15:0] msg;
    logic [7:0]     c;
    msg = {a, ini, f};
    c = 8'h00;
    for (int b = (IW + 16) / 8 - 1; b >= 0; b--) begin
      c = c ^ msg[b*8 +: 8];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic void push_bits(logic [63:0] v, int n);
    for (int j = n - 1; j >= 0; j--) tx_q.push_back(v[j]);
  endfunction

  function automatic void push_frame(logic [7:0] a, logic [IW-1:0] ini, logic [7:0] f,
                                     bit bad_crc);
    push_bits(64'hA5, 8);
    push_bits(64'(a), 8);
    push_bits(64'(ini), IW);
    push_bits(64'(f), 8);
`ifdef CFG_FRAME_LOADER_CRC_EN
    push_bits(64'(crc8(a, ini, f) ^ (bad_crc ? 8'h01 : 8'h00)), 8);
`else
    if (bad_crc) push_bits(64'h0, 0);
`endif
  endfunction

  function automatic logic [63:0] take(int pos, int n);
    logic [63:0] r = '0;
    for (int j = 0; j < n; j++) r = {r[62:0], tx_q[pos+j]};
    return r;
  endfunction

  // Parse the stream in tx_q from a hunting state and apply complete frames.
  function automatic void model_run();
    int          i = 0;
    int          nwin = 0;
    logic [7:0]  win = '0;
    logic [63:0] tmp;
    logic [7:0]  a, f;
    logic [IW-1:0] ini;
    bit          ok;
    while (i < tx_q.size()) begin
      win = {win[6:0], tx_q[i]};
      i++; nwin++;
      if (nwin >= 8 && win == 8'hA5) begin
        if (i + FrameBits - 8 > tx_q.size()) break;
        tmp = take(i, 8);           a   = tmp[7:0];
        tmp = take(i + 8, IW);      ini = tmp[IW-1:0];
        tmp = take(i + 8 + IW, 8);  f   = tmp[7:0];
        ok = 1'b1;
`ifdef CFG_FRAME_LOADER_CRC_EN
        tmp = take(i + 16 + IW, 8);
        ok  = (tmp[7:0] == crc8(a, ini, f));
`endif
        i += FrameBits - 8;
        if (exp_done) return;
        if (ok && a < NT) begin
          exp_lut[a] = ini; exp_en[a] = f[0]; exp_rst[a] = f[1];
        end else if (ok && a == 8'hFF) begin
          exp_done = 1'b1;
          return;
        end else begin
          exp_err = 1'b1;
        end
        win = '0; nwin = 0;
      end
    end
  endfunction

  // Send tx_q[lo..hi], optionally with random idle gaps; busy_chk expects CFG_BUSY in gaps.
  task automatic send_range(int lo, int hi, int max_gap, bit busy_chk);
    for (int i = lo; i <= hi; i++) begin
      if (i > lo && max_gap > 0 && $urandom_range(0, 1) == 1) begin
        int g;
        g = int'($urandom_range(1, max_gap));
        u_if.cfg_valid = 1'b0;
        repeat (g) begin
          @(posedge clk); #1;
          if (busy_chk) begin
            compared++;
            if (busy !== 1'b1) begin
              mismatched++;
              $display("FAIL gap_busy bit %0d: got %b want 1", i, busy);
            end
          end
        end
      end
      u_if.cfg_di    = tx_q[i];
      u_if.cfg_valid = 1'b1;
      @(posedge clk); #1;
      u_if.cfg_valid = 1'b0;
    end
  endtask

  task automatic commit_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    u_if.cfg_valid = 1'b0;
    u_if.cfg_di    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    u_if.cfg_valid = 1'b0;
    u_if.cfg_di    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({lut_init, ff_en, ff_rst} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0", {lut_init, ff_en, ff_rst});
    end
    compared++;
    if ({busy, done, err} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_status: got %b want 000", {busy, done, err});
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    tx_q.delete();
    push_frame(8'h03, 16'hCAFE, 8'h03, 1'b0);
    model_run();
    send_range(0, 6, 0, 1'b0);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL busy_pre_sync: got %b want 0", busy);
    end
    send_range(7, 7, 0, 1'b0);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL busy_rise: got %b want 1", busy);
    end
    send_range(8, tx_q.size() - 1, 0, 1'b0);
    compared++;
    if (busy !== 1'b1 || lut_init !== '0) begin
      mismatched++;
      $display("FAIL commit_latency: busy %b lut %h want busy 1 lut 0", busy, lut_init);
    end
    commit_cycle();
    compared++;
    if (lut_init[63:48] !== 16'hCAFE || ff_en !== 16'h0008 || ff_rst !== 16'h0008) begin
      mismatched++;
      $display("FAIL basic_tile3: lut %h en %h rst %h want CAFE 0008 0008",
               lut_init[63:48], ff_en, ff_rst);
    end
    compared++;
    if ({lut_init, ff_en, ff_rst} !== exp_vec()) begin
      mismatched++;
      $display("FAIL basic_vec: got %h want %h", {lut_init, ff_en, ff_rst}, exp_vec());
    end
    compared++;
    if ({busy, done, err} !== 3'b000) begin
      mismatched++; $display("FAIL basic_status: got %b want 000", {busy, done, err});
    end
  endtask

  task automatic test_gaps();
    do_reset();
    tx_q.delete();
    push_frame(8'h03, 16'hCAFE, 8'h03, 1'b0);
    model_run();
    send_range(0, 7, 5, 1'b0);
    send_range(8, tx_q.size() - 1, 5, 1'b1);
    commit_cycle();
    compared++;
    if ({lut_init, ff_en, ff_rst} !== exp_vec()) begin
      mismatched++;
      $display("FAIL gaps_vec: got %h want %h", {lut_init, ff_en, ff_rst}, exp_vec());
    end
    compared++;
    if ({busy, done, err} !== 3'b000) begin
      mismatched++; $display("FAIL gaps_status: got %b want 000", {busy, done, err});
    end
  endtask

  task automatic test_junk_sync();
    tx_q.delete();
    push_bits(64'b1_0110_1001, 9);
    push_frame(8'h00, 16'h8000, 8'h00, 1'b0);
    model_run();
    send_range(0, tx_q.size() - 1, 0, 1'b0);
    commit_cycle();
    compared++;
    if (lut_init[15:0] !== 16'h8000) begin
      mismatched++; $display("FAIL junk_tile0: got %h want 8000", lut_init[15:0]);
    end
    compared++;
    if ({lut_init, ff_en, ff_rst} !== exp_vec()) begin
      mismatched++;
      $display("FAIL junk_vec: got %h want %h", {lut_init, ff_en, ff_rst}, exp_vec());
    end
  endtask

  task automatic test_bad_frames();
    logic [IW-1:0] ini;
    logic [7:0]    f;
    tx_q.delete();
    push_frame(8'h20, 16'h1234, 8'h03, 1'b0);
    model_run();
    send_range(0, tx_q.size() - 1, 2, 1'b0);
    commit_cycle();
    compared++;
    if ({lut_init, ff_en, ff_rst, err} !== {exp_vec(), 1'b1}) begin
      mismatched++;
      $display("FAIL bad_addr: got %h err %b want %h err 1", {lut_init, ff_en, ff_rst}, err,
               exp_vec());
    end
    ini = 16'($urandom);
    f   = 8'($urandom);
    tx_q.delete();
    push_frame(8'h01, ini, f, 1'b0);
    model_run();
    send_range(0, tx_q.size() - 1, 2, 1'b0);
    commit_cycle();
    compared++;
    if (lut_init[31:16] !== ini || {lut_init, ff_en, ff_rst} !== exp_vec()) begin
      mismatched++;
      $display("FAIL after_bad_tile1: got %h want %h", {lut_init, ff_en, ff_rst}, exp_vec());
    end
`ifdef CFG_FRAME_LOADER_CRC_EN
    tx_q.delete();
    push_frame(8'h04, 16'hBEEF, 8'h01, 1'b1);
    model_run();
    send_range(0, tx_q.size() - 1, 0, 1'b0);
    commit_cycle();
    compared++;
    if (lut_init[79:64] !== 16'h0000 || {lut_init, ff_en, ff_rst, err} !== {exp_vec(), 1'b1})
    begin
      mismatched++;
      $display("FAIL bad_crc: got %h err %b want %h err 1", {lut_init, ff_en, ff_rst}, err,
               exp_vec());
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int n = 0; n < 12; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(NT, 254)) : 8'($urandom_range(0, NT-1));
      tx_q.delete();
      push_frame(a, 16'($urandom), 8'($urandom), $urandom_range(0, 4) == 0);
      model_run();
      send_range(0, tx_q.size() - 1, 3, 1'b0);
      commit_cycle();
      compared++;
      if ({lut_init, ff_en, ff_rst} !== exp_vec() || {busy, done, err} !== {2'b00, exp_err})
      begin
        mismatched++;
        $display("FAIL random_%0d addr %h: got %h st %b want %h st %b", n, a,
                 {lut_init, ff_en, ff_rst}, {busy, done, err}, exp_vec(), {2'b00, exp_err});
      end
    end
  endtask

  task automatic test_done();
    tx_q.delete();
    push_frame(8'hFF, 16'($urandom), 8'h03, 1'b0);
    model_run();
    send_range(0, tx_q.size() - 1, 0, 1'b0);
    commit_cycle();
    compared++;
    if (done !== 1'b1 || busy !== 1'b0 || {lut_init, ff_en, ff_rst} !== exp_vec()) begin
      mismatched++;
      $display("FAIL done_frame: done %b busy %b want done 1 busy 0", done, busy);
    end
    tx_q.delete();
    push_frame(8'h02, 16'h5A5A, 8'h03, 1'b0);
    model_run();
    send_range(0, tx_q.size() - 1, 0, 1'b0);
    commit_cycle();
    compared++;
    if ({lut_init, ff_en, ff_rst} !== exp_vec() || done !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL after_done: got %h done %b busy %b want %h done 1 busy 0",
               {lut_init, ff_en, ff_rst}, done, busy, exp_vec());
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    tx_q.delete();
    push_frame(8'h00, 16'h1357, 8'h01, 1'b0);
    model_run();
    send_range(0, tx_q.size() - 1, 0, 1'b0);
    commit_cycle();
    compared++;
    if (lut_init[15:0] !== 16'h1357 || ff_en[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_abort_tile0: got %h en %b want 1357 en 1", lut_init[15:0], ff_en[0]);
    end
    tx_q.delete();
    push_frame(8'h05, 16'hFFFF, 8'h03, 1'b0);
    send_range(0, 19, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({lut_init, ff_en, ff_rst, busy, done, err} !== '0) begin
      mismatched++;
      $display("FAIL abort_clear: got %h st %b want all 0", {lut_init, ff_en, ff_rst},
               {busy, done, err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    tx_q.delete();
    push_frame(8'h07, 16'($urandom), 8'($urandom), 1'b0);
    model_run();
    send_range(0, tx_q.size() - 1, 2, 1'b0);
    commit_cycle();
    compared++;
    if ({lut_init, ff_en, ff_rst} !== exp_vec() || {busy, done, err} !== 3'b000) begin
      mismatched++;
      $display("FAIL post_abort: got %h st %b want %h st 000", {lut_init, ff_en, ff_rst},
               {busy, done, err}, exp_vec());
    end
  endtask

  initial begin
    u_if.cfg_valid = 1'b0;
    u_if.cfg_di    = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_gaps();
    test_junk_sync();
    test_bad_frames();
    test_random();
    test_done();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
